// File: rtl/stoch_pkg.sv
// stoch_pkg: shared types and limits for the stochastic datapath blocks.
package stoch_pkg;
    typedef enum logic [1:0] {IDLE, ACCUM, HOLD} s2b_state_t;
    localparam int S2B_MAX_WINDOW_LOG2 = 16;
endpackage

// File: rtl/stoch_to_bin_if.sv
// stoch_to_bin_if: stochastic bitstream in, valid/ready ones-count out.
interface stoch_to_bin_if #(parameter int WINDOW_LOG2 = 8) ();
    logic                 start;
    logic                 bit_in;
    logic                 bit_valid;
    logic                 busy;
    logic                 out_valid;
    logic                 out_ready;
    logic [WINDOW_LOG2:0] count_out;
    modport master (output start, bit_in, bit_valid, out_ready, input busy, out_valid, count_out);
    modport slave  (input start, bit_in, bit_valid, out_ready, output busy, out_valid, count_out);
endinterface

// File: rtl/stoch_window_ctr.sv
// stoch_window_ctr: enable/clear counter; hit flags the enabled step that reaches TERM.
module stoch_window_ctr #(
    parameter int           W    = 9,
    parameter logic [W-1:0] TERM = '1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] cnt,
    output logic         hit
);
    assign hit = en && (cnt == TERM - 1'b1);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt <= '0;
        else        cnt <= clr ? '0 : cnt + W'(en);
    end
endmodule

// File: rtl/stoch_to_bin.sv
// stoch_to_bin: counts ones over 2^WINDOW_LOG2 accepted stream bits and
// hands the count downstream over valid/ready.
module stoch_to_bin import stoch_pkg::*; #(
    parameter int WINDOW_LOG2 = 8
) (
    input logic           clk,
    input logic           rst_n,
    stoch_to_bin_if.slave s
);
    localparam int           W    = WINDOW_LOG2 + 1;
    localparam logic [W-1:0] TERM = {1'b1, {WINDOW_LOG2{1'b0}}};

    if (WINDOW_LOG2 < 1 || WINDOW_LOG2 > S2B_MAX_WINDOW_LOG2) begin : g_bad_window
        $error("stoch_to_bin: WINDOW_LOG2 out of range");
    end

    s2b_state_t   state;
    logic         acc, clr, smp_hit, ones_hit_unused;
    logic [W-1:0] smp_cnt_unused, ones_cnt;

    assign acc = (state == ACCUM) && s.bit_valid;
    assign clr = s.start && (state == IDLE || (state == HOLD && s.out_ready));

    stoch_window_ctr #(.W(W), .TERM(TERM)) u_smp (
        .clk(clk), .rst_n(rst_n), .clr(clr), .en(acc),
        .cnt(smp_cnt_unused), .hit(smp_hit)
    );

    stoch_window_ctr #(.W(W), .TERM(TERM)) u_ones (
        .clk(clk), .rst_n(rst_n), .clr(clr), .en(acc && s.bit_in),
        .cnt(ones_cnt), .hit(ones_hit_unused)
    );

    // The closing bit is folded into count_out on the same edge it is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            s.busy      <= 1'b0;
            s.out_valid <= 1'b0;
            s.count_out <= '0;
        end else begin
            case (state)
                IDLE: if (s.start) begin
                    state  <= ACCUM;
                    s.busy <= 1'b1;
                end
                ACCUM: if (smp_hit) begin
                    state       <= HOLD;
                    s.out_valid <= 1'b1;
                    s.count_out <= ones_cnt + W'(s.bit_in);
                end
                HOLD: if (s.out_ready) begin
                    state       <= s.start ? ACCUM : IDLE;
                    s.busy      <= s.start;
                    s.out_valid <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/stoch_to_bin.md
# stoch_to_bin

Stochastic-to-binary decoder for the probabilistic-computing datapath. It counts the ones in a fixed window of 2^WINDOW_LOG2 accepted stream bits, for example the output of an AND/OR stochastic gate network, and returns the count as an unsigned binary value. It is the receiving end of the stochastic bitstream interface fed by the stochastic number generators. The result is delivered over a valid/ready handshake so that downstream logic can stall it.

## Interface
- WINDOW_LOG2, default 8: window length is 2^WINDOW_LOG2 accepted bits; legal range 1..16.
- clk  input  1  single clock; all logic is rising-edge.
- rst_n  input  1  asynchronous, active-low reset; deassertion is synchronous to clk externally.
- start  input  1  request a new window; sampled only in IDLE, or in HOLD on the handshake cycle.
- bit_in  input  1  stochastic stream bit.
- bit_valid  input  1  bit_in is meaningful this cycle.
- busy  output  1  high in ACCUM and HOLD.
- out_valid  output  1  result available; high exactly in HOLD.
- out_ready  input  1  consumer accepts the result.
- count_out  output  WINDOW_LOG2+1  ones count, 0..2^WINDOW_LOG2.

## Operation
- States: IDLE, ACCUM, HOLD.
- IDLE: ignores the stream.
  - start=1 → ACCUM; clears sample_cnt and ones_cnt.
- ACCUM: each cycle with bit_valid=1, sample_cnt += 1 and ones_cnt += bit_in.
  - Cycles with bit_valid=0 leave both counters unchanged.
  - The accepted bit that brings sample_cnt to 2^WINDOW_LOG2 is included in the count. On that cycle, count_out is registered with the final value and the block moves to HOLD.
  - start is ignored in ACCUM.
- HOLD: out_valid=1 and count_out is stable; bit_in and bit_valid are ignored.
  - out_valid & out_ready → IDLE, or → ACCUM with the counters cleared if start=1 on the same cycle (back-to-back windows).
  - start without out_ready is ignored.
- Width rules:
  - sample_cnt is WINDOW_LOG2+1 bits.
  - ones_cnt is WINDOW_LOG2+1 bits and cannot overflow, since its maximum of 2^WINDOW_LOG2 fits.
  - No saturation or wrap logic is required.
- Reset (async, any state, including mid-window): state=IDLE, busy=0, out_valid=0, count_out=0, and both internal counters are 0. The partial window is discarded.
- count_out keeps its last value after the handshake until the next window completes.

## Timing
- start in cycle t (from IDLE): busy=1 from t+1; the first bit that can be counted is in cycle t+1.
- Minimum latency: with bit_valid held high, the 2^WINDOW_LOG2 bits are accepted in cycles t+1 .. t+2^WINDOW_LOG2. out_valid rises in cycle t+2^WINDOW_LOG2+1.
- Handshake completes on the rising edge where out_valid & out_ready are both high. out_valid falls the following cycle.
- Back-to-back: the handshake cycle with start=1 gives ACCUM the next cycle, so there is zero idle gap between windows.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Structure
- Shared package stoch_pkg:
  - state enum s2b_state_t {IDLE, ACCUM, HOLD};
  - constant S2B_MAX_WINDOW_LOG2 = 16 (used in a parameter-range assertion).
- One sub-module is natural: stoch_window_ctr, an enable/clear counter of width WINDOW_LOG2+1 with a terminal flag. It is instantiated twice: once for the sample count, with terminal at 2^WINDOW_LOG2, and once for the ones count, where the terminal flag is unused.
- The FSM and output registers live in the top module.

## Test plan
Directed scenarios, all with WINDOW_LOG2=4 (16-bit window):
- **All ones:** start, then 16 cycles of bit_valid=1, bit_in=1 → out_valid rises 17 cycles after start, count_out=16.
- **Alternating with gaps:** alternating 1,0 with a bit_valid=0 gap inserted every third cycle → count_out=8. Gap cycles must not be counted, and the window closes only after the 16th valid bit.
- **Backpressure:** out_ready held low for 10 cycles in HOLD while bit_in toggles → count_out and out_valid stay stable, and the bits arriving during the stall are not counted.
- **Back-to-back windows:** handshake with start=1 on the same cycle, first window all zeros, second window has 5 ones → first result 0, second result 5. busy never drops between the windows.
- **Reset mid-window:** rst_n pulsed low after 7 accepted ones → outputs go to 0 immediately (asynchronously). A following start plus 16 ones gives count_out=16, with no residue from the aborted window.
- **Start ignored while busy:** start pulses in ACCUM and in HOLD without out_ready → no counter clear and no state change. The result equals the count of the original window.
